// File: rtl/rob_pkg.sv
// Shared types and sizing for the early-recovery reorder buffer.
package rob_pkg;

   localparam int DEPTH  = 8;
   localparam int N      = 2;
   localparam int CDB_W  = 2;
   localparam int PC_W   = 32;
   localparam int RIDX_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int SEL_W  = (CDB_W > 1) ? $clog2(CDB_W) : 1;

   typedef logic [RIDX_W-1:0] robn_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef struct packed {
      logic            valid;
      logic            executed;
      logic            halt;
      logic            illegal;
      logic            is_branch;
      logic            is_cond;
      logic            predict_taken;
      logic            taken;
      logic            success;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] predict_target;
      logic [PC_W-1:0] target;
   } rob_entry_t;

   typedef struct packed {
      robn_t           robn;
      logic            taken;
      logic [PC_W-1:0] target;
   } rob_cdb_packet_t;

   function automatic logic mispredict(
      input rob_entry_t      e,
      input logic            taken,
      input logic [PC_W-1:0] target
   );
      if (!e.is_branch) return 1'b0;
      if (e.is_cond)
         return (taken != e.predict_taken) ||
                (taken && (target != e.predict_target));
      return target != e.predict_target;
   endfunction

endpackage

// File: rtl/rob_age_select.sv
// Picks the oldest candidate robn, age measured from head.
module rob_age_select
   import rob_pkg::*;
(
   input  robn_t                   head,
   input  logic [CDB_W-1:0]        cand,
   input  robn_t [CDB_W-1:0]       robn,
   output logic                    any,
   output logic [SEL_W-1:0]        sel
);

   robn_t best_age;
   robn_t age;

   always_comb begin
      any      = 1'b0;
      sel      = '0;
      best_age = '0;
      age      = '0;
      for (int c = 0; c < CDB_W; c++) begin
         age = robn[c] - head;
         if (cand[c] && (!any || age < best_age)) begin
            any      = 1'b1;
            sel      = SEL_W'(c);
            best_age = age;
         end
      end
   end

endmodule

// File: rtl/rob_early_recover.sv
// Reorder buffer with in-order retire and same-edge tail rollback
// on the oldest CDB mispredict; front-end redirect follows one cycle later.
module rob_early_recover
   import rob_pkg::*;
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic [N-1:0]                  dis_valid,
   input  rob_entry_t [N-1:0]            dis_entries,
   output robn_t [N-1:0]                 dis_robn,
   output logic                          almost_full,
   input  logic [CDB_W-1:0]              cdb_valid,
   input  rob_cdb_packet_t [CDB_W-1:0]   cdb_packets,
   output logic [N-1:0]                  rt_valid,
   output rob_entry_t [N-1:0]            rt_entries,
   output logic                          recover_valid,
   output robn_t                         recover_robn,
   output logic [PC_W-1:0]               recover_pc,
   output logic                          halted,
   output cnt_t                          count,
   output robn_t                         head,
   output robn_t                         tail
);

   rob_entry_t rob [DEPTH];

   rob_entry_t [N-1:0] dis_wr;
   cnt_t               free, n_req, n_dis, n_ret;
   logic               pre, stop, ret_halt;
   robn_t              rt_idx;

   logic [CDB_W-1:0]   cdb_hit, cdb_mp;
   robn_t [CDB_W-1:0]  cdb_robn;
   logic               rec_any;
   logic [SEL_W-1:0]   rec_sel;
   rob_cdb_packet_t    rec_pkt;
   robn_t              rec_robn, rec_age;
   logic [PC_W-1:0]    rec_pc;

   always_comb begin
      free        = cnt_t'(DEPTH) - count;
      almost_full = free < cnt_t'(N);
      n_req       = '0;
      pre         = 1'b1;
      for (int i = 0; i < N; i++) begin
         pre         = pre & dis_valid[i];
         if (pre) n_req = n_req + cnt_t'(1);
         dis_robn[i] = tail + robn_t'(i);
         dis_wr[i]       = dis_entries[i];
         dis_wr[i].valid = 1'b1;
      end
      if (halted || rec_any) n_dis = '0;
      else n_dis = (n_req > free) ? free : n_req;
   end

   // Retire stops at the first unexecuted entry and right after a halt.
   always_comb begin
      rt_valid   = '0;
      rt_entries = '0;
      n_ret      = '0;
      ret_halt   = 1'b0;
      stop       = halted;
      rt_idx     = '0;
      for (int i = 0; i < N; i++) begin
         rt_idx = head + robn_t'(i);
         if (!stop && cnt_t'(i) < count && rob[rt_idx].executed) begin
            rt_valid[i]   = 1'b1;
            rt_entries[i] = rob[rt_idx];
            n_ret         = n_ret + cnt_t'(1);
            if (rob[rt_idx].halt || rob[rt_idx].illegal) begin
               ret_halt = 1'b1;
               stop     = 1'b1;
            end
         end else begin
            stop = 1'b1;
         end
      end
   end

   // A repeated robn on a later channel is dropped in favour of the earlier one.
   always_comb begin
      cdb_hit  = '0;
      cdb_mp   = '0;
      cdb_robn = '0;
      for (int c = 0; c < CDB_W; c++) begin
         cdb_robn[c] = cdb_packets[c].robn;
         cdb_hit[c]  = cdb_valid[c] &&
                       (cnt_t'(robn_t'(cdb_packets[c].robn - head)) < count) &&
                       !rob[cdb_packets[c].robn].executed;
         for (int p = 0; p < c; p++)
            if (cdb_hit[p] && cdb_packets[p].robn == cdb_packets[c].robn)
               cdb_hit[c] = 1'b0;
         cdb_mp[c] = mispredict(rob[cdb_packets[c].robn],
                                cdb_packets[c].taken,
                                cdb_packets[c].target);
      end
   end

   rob_age_select u_age_select (
      .head (head),
      .cand (cdb_hit & cdb_mp),
      .robn (cdb_robn),
      .any  (rec_any),
      .sel  (rec_sel)
   );

   assign rec_pkt  = cdb_packets[rec_sel];
   assign rec_robn = rec_pkt.robn;
   assign rec_age  = rec_robn - head;
   assign rec_pc   = rec_pkt.taken ? rec_pkt.target
                                   : rob[rec_robn].pc + PC_W'(4);

   always_ff @(posedge clock) begin
      if (reset) begin
         count         <= '0;
         head          <= '0;
         tail          <= '0;
         halted        <= 1'b0;
         recover_valid <= 1'b0;
         recover_robn  <= '0;
         recover_pc    <= '0;
         for (int d = 0; d < DEPTH; d++) rob[d] <= '0;
      end else begin
         for (int i = 0; i < N; i++)
            if (rt_valid[i]) rob[head + robn_t'(i)].valid <= 1'b0;
         for (int c = 0; c < CDB_W; c++)
            if (cdb_hit[c]) begin
               rob[cdb_packets[c].robn].executed <= 1'b1;
               rob[cdb_packets[c].robn].taken    <= cdb_packets[c].taken;
               rob[cdb_packets[c].robn].target   <= cdb_packets[c].target;
               rob[cdb_packets[c].robn].success  <= !cdb_mp[c];
            end
         for (int i = 0; i < N; i++)
            if (cnt_t'(i) < n_dis) rob[tail + robn_t'(i)] <= dis_wr[i];
         if (rec_any)
            for (int d = 0; d < DEPTH; d++)
               if (robn_t'(robn_t'(d) - head) > rec_age) rob[d].valid <= 1'b0;
         head   <= head + robn_t'(n_ret);
         tail   <= rec_any ? rec_robn + robn_t'(1) : tail + robn_t'(n_dis);
         count  <= rec_any ? cnt_t'(rec_age) + cnt_t'(1) - n_ret
                           : count + n_dis - n_ret;
         halted <= halted | ret_halt;
         recover_valid <= rec_any;
         recover_robn  <= rec_any ? rec_robn : '0;
         recover_pc    <= rec_any ? rec_pc : '0;
      end
   end

   always @(posedge clock)
      if (!reset && !halted && !rec_any)
         assert (n_req <= free) else $error("rob dispatch overflow");

endmodule

// File: tb/tb_rob_early_recover.sv
// Random and directed stimulus against a queue-based window model.
module tb_rob_early_recover;
   import rob_pkg::*;

   logic                        clock = 1'b0;
   logic                        reset = 1'b1;
   logic [N-1:0]                dis_valid;
   rob_entry_t [N-1:0]          dis_entries;
   robn_t [N-1:0]               dis_robn;
   logic                        almost_full;
   logic [CDB_W-1:0]            cdb_valid;
   rob_cdb_packet_t [CDB_W-1:0] cdb_packets;
   logic [N-1:0]                rt_valid;
   rob_entry_t [N-1:0]          rt_entries;
   logic                        recover_valid;
   robn_t                       recover_robn;
   logic [PC_W-1:0]             recover_pc;
   logic                        halted;
   cnt_t                        count;
   robn_t                       head, tail;

   rob_early_recover dut (
      .clock(clock), .reset(reset),
      .dis_valid(dis_valid), .dis_entries(dis_entries),
      .dis_robn(dis_robn), .almost_full(almost_full),
      .cdb_valid(cdb_valid), .cdb_packets(cdb_packets),
      .rt_valid(rt_valid), .rt_entries(rt_entries),
      .recover_valid(recover_valid), .recover_robn(recover_robn),
      .recover_pc(recover_pc), .halted(halted),
      .count(count), .head(head), .tail(tail)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // window model: mq[0] is the oldest entry, its robn is mhead
   rob_entry_t      mq[$];
   int              mhead = 0;
   bit              mhalted = 0;
   bit              mrv = 0;
   int              mrr = 0;
   logic [PC_W-1:0] mrp = '0;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      dis_valid   = '0;
      dis_entries = '0;
      cdb_valid   = '0;
      cdb_packets = '0;
   endtask

   function automatic rob_entry_t mk(input int pc, input bit ex,
                                     input bit br, input bit cond,
                                     input bit pt, input int ptgt,
                                     input bit hlt);
      rob_entry_t e;
      e = '0;
      e.pc = pc; e.executed = ex; e.success = ex;
      e.is_branch = br; e.is_cond = cond;
      e.predict_taken = pt; e.predict_target = ptgt;
      e.halt = hlt;
      return e;
   endfunction

   function automatic bit model_mp(input rob_entry_t e, input bit t,
                                   input logic [PC_W-1:0] tg);
      bit wrong_dir, wrong_tgt;
      if (!e.is_branch) return 0;
      wrong_tgt = (tg != e.predict_target);
      if (!e.is_cond) return wrong_tgt;
      wrong_dir = (t != e.predict_taken);
      return wrong_dir || (t && wrong_tgt);
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      clr();
      mq.delete(); mhead = 0; mhalted = 0; mrv = 0; mrr = 0; mrp = '0;
      #1;
      check("rst_count", count, 0);
      check("rst_head", head, 0);
      check("rst_tail", tail, 0);
      check("rst_halted", halted, 0);
      check("rst_afull", almost_full, 0);
      check("rst_rt_valid", rt_valid, 0);
      check("rst_rt_entries", rt_entries, 0);
      check("rst_rec_valid", recover_valid, 0);
      check("rst_rec_robn", recover_robn, 0);
      check("rst_rec_pc", recover_pc, 0);
      check("rst_dis_robn0", dis_robn[0], 0);
   endtask

   // Compare against the model, advance the model, then clock once.
   task automatic tick();
      int sz, mtail, nret, best, p, k, take;
      bit hnow, mp;
      logic [PC_W-1:0] bpc;
      rob_entry_t e;
      #1;
      sz = mq.size();
      mtail = (mhead + sz) % DEPTH;
      nret = 0; hnow = 0;
      if (!mhalted)
         for (int i = 0; i < N; i++) begin
            if (i < sz && mq[i].executed) begin
               nret++;
               if (mq[i].halt || mq[i].illegal) begin hnow = 1; break; end
            end else break;
         end
      check("count", count, sz);
      check("head", head, mhead);
      check("tail", tail, mtail);
      check("almost_full", almost_full, (DEPTH - sz) < N);
      check("halted", halted, mhalted);
      check("rec_valid", recover_valid, mrv);
      if (mrv) begin
         check("rec_robn", recover_robn, mrr);
         check("rec_pc", recover_pc, mrp);
      end
      for (int i = 0; i < N; i++) begin
         check("dis_robn", dis_robn[i], (mtail + i) % DEPTH);
         check("rt_valid", rt_valid[i], i < nret);
         if (i < nret) check("rt_entry", rt_entries[i], mq[i]);
      end
      best = -1; bpc = '0;
      for (int c = 0; c < CDB_W; c++)
         if (cdb_valid[c]) begin
            p = (int'(cdb_packets[c].robn) - mhead + DEPTH) % DEPTH;
            if (p < sz && !mq[p].executed) begin
               mp = model_mp(mq[p], cdb_packets[c].taken, cdb_packets[c].target);
               mq[p].executed = 1;
               mq[p].taken = cdb_packets[c].taken;
               mq[p].target = cdb_packets[c].target;
               mq[p].success = !mp;
               if (mp && (best < 0 || p < best)) begin
                  best = p;
                  bpc = cdb_packets[c].taken ? cdb_packets[c].target
                                             : mq[p].pc + 4;
               end
            end
         end
      mrv = (best >= 0);
      mrr = (mhead + (best < 0 ? 0 : best)) % DEPTH;
      mrp = bpc;
      if (best >= 0) mq = mq[0:best];
      else if (!mhalted) begin
         k = 0;
         for (int i = 0; i < N; i++) if (dis_valid[i] && k == i) k++;
         take = (k > DEPTH - sz) ? DEPTH - sz : k;
         for (int i = 0; i < take; i++) begin
            e = dis_entries[i];
            e.valid = 1;
            mq.push_back(e);
         end
      end
      for (int i = 0; i < nret; i++) void'(mq.pop_front());
      mhead = (mhead + nret) % DEPTH;
      if (hnow) mhalted = 1;
      @(posedge clock); #1;
   endtask

   task automatic rand_inputs();
      int sz, free, k, p;
      sz = mq.size();
      free = DEPTH - sz;
      k = $urandom_range(0, N);
      if (k > free) k = free;
      dis_valid = N'((1 << k) - 1);
      for (int i = 0; i < N; i++) begin
         dis_entries[i] = mk($urandom_range(0, 255) * 4,
                             $urandom_range(0, 9) < 3,
                             $urandom_range(0, 9) < 4,
                             $urandom_range(0, 1), $urandom_range(0, 1),
                             $urandom_range(0, 15) * 4,
                             $urandom_range(0, 99) < 2);
         dis_entries[i].illegal = ($urandom_range(0, 199) == 0);
      end
      for (int c = 0; c < CDB_W; c++) begin
         cdb_valid[c] = ($urandom_range(0, 2) != 0);
         cdb_packets[c].taken = $urandom_range(0, 1);
         cdb_packets[c].target = $urandom_range(0, 15) * 4;
         if (sz > 0 && $urandom_range(0, 3) != 0) begin
            p = $urandom_range(0, sz - 1);
            cdb_packets[c].robn = robn_t'((mhead + p) % DEPTH);
            if ($urandom_range(0, 1))
               cdb_packets[c].target = mq[p].predict_target;
         end else begin
            cdb_packets[c].robn = robn_t'($urandom_range(0, DEPTH - 1));
         end
      end
      if (cdb_packets[1].robn == cdb_packets[0].robn) cdb_valid[1] = 1'b0;
   endtask

   initial begin
      clr();
      do_reset();

      // fill to full; tail wraps to 0
      for (int i = 0; i < 4; i++) begin
         dis_valid = 2'b11;
         dis_entries[0] = mk(16 * i, 0, 0, 0, 0, 0, 0);
         dis_entries[1] = mk(16 * i + 4, 0, 0, 0, 0, 0, 0);
         tick();
      end
      clr();
      check("fill_count", count, 8);
      check("fill_tail", tail, 0);
      check("fill_afull", almost_full, 1);
      tick();

      // executed-on-dispatch stream
      do_reset();
      for (int i = 0; i < 6; i++) begin
         dis_valid = 2'b11;
         dis_entries[0] = mk(8 * i, 1, 0, 0, 0, 0, 0);
         dis_entries[1] = mk(8 * i + 4, 1, 0, 0, 0, 0, 0);
         tick();
      end
      clr();
      check("stream_count", count, 2);
      check("stream_head", head, 2);
      tick();

      // out-of-order writeback, in-order retire
      do_reset();
      for (int i = 0; i < 2; i++) begin
         dis_valid = 2'b11;
         dis_entries[0] = mk(8 * i, 0, 0, 0, 0, 0, 0);
         dis_entries[1] = mk(8 * i + 4, 0, 0, 0, 0, 0, 0);
         tick();
      end
      clr();
      cdb_valid = 2'b01; cdb_packets[0].robn = 1;
      tick();
      clr();
      check("ooo_no_retire", rt_valid, 2'b00);
      tick();
      cdb_valid = 2'b01; cdb_packets[0].robn = 0;
      tick();
      clr();
      check("ooo_retire2", rt_valid, 2'b11);
      tick();
      check("ooo_head", head, 2);

      // mispredict rolls tail back while dispatch is asserted
      do_reset();
      dis_valid = 2'b11;
      dis_entries[0] = mk('h0, 0, 0, 0, 0, 0, 0);
      dis_entries[1] = mk('h4, 0, 0, 0, 0, 0, 0);
      tick();
      dis_entries[0] = mk('h40, 0, 1, 1, 0, 'h80, 0);
      dis_entries[1] = mk('h44, 0, 0, 0, 0, 0, 0);
      tick();
      dis_entries[0] = mk('h48, 0, 0, 0, 0, 0, 0);
      dis_entries[1] = mk('h4c, 0, 0, 0, 0, 0, 0);
      tick();
      dis_entries[0] = mk('h50, 0, 0, 0, 0, 0, 0);
      dis_entries[1] = mk('h54, 0, 0, 0, 0, 0, 0);
      cdb_valid = 2'b01;
      cdb_packets[0].robn = 2; cdb_packets[0].taken = 1;
      cdb_packets[0].target = 'h100;
      tick();
      clr();
      check("rec1_tail", tail, 3);
      check("rec1_count", count, 3);
      check("rec1_valid", recover_valid, 1);
      check("rec1_robn", recover_robn, 2);
      check("rec1_pc", recover_pc, 'h100);
      tick();
      check("rec1_pulse_off", recover_valid, 0);

      // two mispredicts in one cycle around the wrap; oldest wins
      do_reset();
      for (int i = 0; i < 3; i++) begin
         dis_valid = 2'b11;
         dis_entries[0] = mk(8 * i, 1, 0, 0, 0, 0, 0);
         dis_entries[1] = mk(8 * i + 4, 1, 0, 0, 0, 0, 0);
         tick();
      end
      dis_entries[0] = mk('h60, 0, 1, 1, 0, 'h10, 0);
      dis_entries[1] = mk('h70, 0, 1, 1, 0, 'h10, 0);
      tick();
      dis_entries[0] = mk('h80, 0, 0, 0, 0, 0, 0);
      dis_entries[1] = mk('h90, 0, 1, 1, 0, 'h10, 0);
      tick();
      clr();
      check("wrap_head", head, 6);
      cdb_valid = 2'b11;
      cdb_packets[0].robn = 1; cdb_packets[0].taken = 1;
      cdb_packets[0].target = 'h200;
      cdb_packets[1].robn = 7; cdb_packets[1].taken = 1;
      cdb_packets[1].target = 'h300;
      tick();
      clr();
      check("rec2_robn", recover_robn, 7);
      check("rec2_pc", recover_pc, 'h300);
      check("rec2_tail", tail, 0);
      check("rec2_count", count, 2);
      tick();

      // halt retires alone and freezes the buffer
      do_reset();
      dis_valid = 2'b11;
      dis_entries[0] = mk('h0, 1, 0, 0, 0, 0, 1);
      dis_entries[1] = mk('h4, 1, 0, 0, 0, 0, 0);
      tick();
      clr();
      check("halt_rt", rt_valid, 2'b01);
      tick();
      dis_valid = 2'b11;
      dis_entries[0] = mk('h8, 1, 0, 0, 0, 0, 0);
      tick();
      tick();
      clr();
      check("halt_flag", halted, 1);
      check("halt_count", count, 1);
      tick();
      do_reset();

      // random traffic with occasional mid-operation reset
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rand_inputs();
         if ((mhalted && $urandom_range(0, 5) == 0) ||
             $urandom_range(0, 299) == 0)
            do_reset();
         else
            tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
